// File: rtl/cnt10_ctrl.sv
// cnt10_ctrl - control sequencer for the lab-board decimal counter.
//
// Takes the three raw active-low push buttons and the switch bank,
// synchronises and debounces the buttons, runs a run/pause/load/clear
// state machine and drives the counter with single-cycle command strobes.
// The counting-rate prescaler lives here so the counter itself runs on
// the undivided CLK_50 and only advances when CNT_EN is high.
//
// Parameters:
//   DIV_LEN   - CLK_50 cycles between CNT_EN strobes while running (>= 2)
//   DB_LEN    - consecutive differing samples needed to accept a new
//               button level (>= 1)
//   AUTO_STOP - 1: stop at terminal count instead of wrapping
//
// Ports:
//   CLK_50    in   system clock, 50 MHz
//   RST       in   synchronous reset, active-high
//   KEY[2:0]  in   raw buttons, active-low: 0=clear, 1=load, 2=start/pause
//   SW[3:0]   in   load value
//   CNT_COUT  in   counter terminal-count flag (count = 9)
//   CNT_EN    out  one-cycle advance strobe
//   CNT_LOAD  out  one-cycle load strobe
//   CNT_CLR   out  one-cycle clear strobe
//   LOAD_VAL  out  value to load, valid while CNT_LOAD=1 (0 otherwise)
//   STATE     out  FSM state: IDLE=00 RUN=01 PAUSE=10 LOAD=11
//   RUN_LED   out  high while STATE=RUN

module cnt10_ctrl #(
  parameter int unsigned DIV_LEN   = 50_000_000,
  parameter int unsigned DB_LEN    = 1_000_000,
  parameter bit          AUTO_STOP = 1'b0
) (
  input  logic       CLK_50,
  input  logic       RST,
  input  logic [2:0] KEY,
  input  logic [3:0] SW,
  input  logic       CNT_COUT,
  output logic       CNT_EN,
  output logic       CNT_LOAD,
  output logic       CNT_CLR,
  output logic [3:0] LOAD_VAL,
  output logic [1:0] STATE,
  output logic       RUN_LED
);

  localparam int DBW = (DB_LEN > 1) ? $clog2(DB_LEN) : 1;
  localparam int PW  = $clog2(DIV_LEN);
  localparam logic [DBW-1:0] DB_CNT_LAST = DBW'(DB_LEN - 1);
  localparam logic [PW-1:0]  PRESC_LAST  = PW'(DIV_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LOAD  = 2'b11
  } state_t;

  logic           clk_internal;
  logic [2:0]     sync1;
  logic [2:0]     sync2;
  logic [2:0]     stable;
  logic [2:0]     press;
  logic [DBW-1:0] db_cnt [3];

  state_t         state;
  logic           from_run;
  logic [PW-1:0]  presc;

  logic           cmd_clr;
  logic           cmd_load;
  logic           cmd_start;
  logic           tick;

  assign clk_internal = CLK_50;

  // Two-flop synchroniser followed by a per-key debouncer. The counter
  // tracks how many consecutive synchronised samples disagree with the
  // accepted level; on the DB_LEN-th such sample the level flips. A flip
  // from released (1) to pressed (0) raises PRESS for exactly one cycle.
  always_ff @(posedge clk_internal) begin
    if (RST) begin
      sync1  <= 3'b111;
      sync2  <= 3'b111;
      stable <= 3'b111;
      press  <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_CNT_LAST) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
          press[i]  <= stable[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Only one press acts per cycle: clear beats load beats start.
  assign cmd_clr   = press[0];
  assign cmd_load  = press[1] & ~press[0];
  assign cmd_start = press[2] & ~press[1] & ~press[0];
  assign tick      = (presc == PRESC_LAST);

  // Main sequencer. Strobes and LOAD_VAL default low every cycle so each
  // command is a single-cycle pulse and at most one strobe is ever high.
  // The prescaler only advances while staying in RUN; any other path
  // (including RUN -> LOAD -> RUN) resets it, so re-entering RUN always
  // waits a full interval before the first CNT_EN. RUN_LED is loaded with
  // the same decision as the next state so it tracks STATE exactly.
  always_ff @(posedge clk_internal) begin
    if (RST) begin
      state    <= IDLE;
      from_run <= 1'b0;
      presc    <= '0;
      CNT_EN   <= 1'b0;
      CNT_LOAD <= 1'b0;
      CNT_CLR  <= 1'b0;
      LOAD_VAL <= 4'd0;
      RUN_LED  <= 1'b0;
    end else begin
      CNT_EN   <= 1'b0;
      CNT_LOAD <= 1'b0;
      CNT_CLR  <= 1'b0;
      LOAD_VAL <= 4'd0;
      RUN_LED  <= 1'b0;
      presc    <= '0;
      case (state)
        IDLE, PAUSE: begin
          if (cmd_clr) begin
            CNT_CLR <= 1'b1;
            state   <= IDLE;
          end else if (cmd_load) begin
            CNT_LOAD <= 1'b1;
            LOAD_VAL <= (SW > 4'd9) ? 4'd9 : SW;
            from_run <= 1'b0;
            state    <= LOAD;
          end else if (cmd_start) begin
            RUN_LED <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (cmd_clr) begin
            CNT_CLR <= 1'b1;
            state   <= IDLE;
          end else if (cmd_load) begin
            CNT_LOAD <= 1'b1;
            LOAD_VAL <= (SW > 4'd9) ? 4'd9 : SW;
            from_run <= 1'b1;
            state    <= LOAD;
          end else if (cmd_start) begin
            state <= PAUSE;
          end else if (tick) begin
            if (AUTO_STOP && CNT_COUT) begin
              state <= PAUSE;
            end else begin
              CNT_EN  <= 1'b1;
              RUN_LED <= 1'b1;
            end
          end else begin
            presc   <= presc + 1'b1;
            RUN_LED <= 1'b1;
          end
        end
        LOAD: begin
          if (from_run) begin
            RUN_LED <= 1'b1;
            state   <= RUN;
          end else begin
            state <= PAUSE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_cnt10_ctrl.sv
// Testbench for cnt10_ctrl with DIV_LEN=4, DB_LEN=3. Two instances share
// all stimulus, one with AUTO_STOP=0 and one with AUTO_STOP=1. A
// behavioural model predicts every output of both instances each cycle;
// directed steps add hand-computed latency and value expectations.

module tb_cnt10_ctrl;

  localparam int DIV = 4;
  localparam int DB  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] key;
  logic [3:0] sw;
  logic       cout;

  logic [1:0] en;
  logic [1:0] ld;
  logic [1:0] clr;
  logic [1:0] led;
  logic [3:0] val [2];
  logic [1:0] st  [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cnt10_ctrl #(.DIV_LEN(DIV), .DB_LEN(DB), .AUTO_STOP(1'b0)) dut0 (
    .CLK_50(clk), .RST(rst), .KEY(key), .SW(sw), .CNT_COUT(cout),
    .CNT_EN(en[0]), .CNT_LOAD(ld[0]), .CNT_CLR(clr[0]),
    .LOAD_VAL(val[0]), .STATE(st[0]), .RUN_LED(led[0])
  );

  cnt10_ctrl #(.DIV_LEN(DIV), .DB_LEN(DB), .AUTO_STOP(1'b1)) dut1 (
    .CLK_50(clk), .RST(rst), .KEY(key), .SW(sw), .CNT_COUT(cout),
    .CNT_EN(en[1]), .CNT_LOAD(ld[1]), .CNT_CLR(clr[1]),
    .LOAD_VAL(val[1]), .STATE(st[1]), .RUN_LED(led[1])
  );

  // Compare one value and keep the running tallies.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive the buttons at the current falling edge and hold for n cycles.
  task automatic applyStimulus(input logic [2:0] k, input int n);
    key = k;
    repeat (n) @(negedge clk);
  endtask

  // Hold a button pattern long enough to register, then release fully.
  task automatic pressKey(input logic [2:0] k);
    applyStimulus(k, 7);
    applyStimulus(3'b111, 8);
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return led[0];
      1:       return en[0];
      2:       return ld[0];
      3:       return clr[0];
      default: return 1'b0;
    endcase
  endfunction

  // Count falling edges until the selected output goes high (bounded).
  task automatic waitSig(input int which, output int n);
    n = 0;
    while (sel(which) !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------------------------------------------------------
  // Behavioural model. A button level is accepted once the last DB
  // synchronised samples all disagree with the current level; the
  // synchroniser is a plain two-sample delay of KEY. The prescaler is
  // modelled as the age (in cycles) of the current stay in RUN.
  // ---------------------------------------------------------------
  bit       m_valid = 1'b0;
  int       m_cyc   = 0;
  bit [2:0] m_pipe1, m_pipe2, m_stable, m_press, old_press;
  int       m_last_agree [3];
  int       m_st [2];
  bit       m_from_run [2];
  int       m_age [2];
  int       e_en [2], e_ld [2], e_clr [2], e_val [2], e_led [2];

  task automatic modelFsm(input int a, input int win);
    int prev, nxt;
    bit tick;
    prev     = m_st[a];
    nxt      = prev;
    e_en[a]  = 0;
    e_ld[a]  = 0;
    e_clr[a] = 0;
    e_val[a] = 0;
    tick     = (prev == 1) && (m_age[a] % DIV == DIV - 1);
    if (prev == 3) begin
      nxt = m_from_run[a] ? 1 : 2;
    end else if (win == 1) begin
      e_clr[a] = 1;
      nxt      = 0;
    end else if (win == 2) begin
      e_ld[a]       = 1;
      e_val[a]      = (int'(sw) > 9) ? 9 : int'(sw);
      m_from_run[a] = (prev == 1);
      nxt           = 3;
    end else if (win == 3) begin
      nxt = (prev == 1) ? 2 : 1;
    end else if (tick) begin
      if (a == 1 && cout) nxt = 2;
      else e_en[a] = 1;
    end
    m_age[a] = (prev == 1 && nxt == 1) ? m_age[a] + 1 : 0;
    m_st[a]  = nxt;
    e_led[a] = (nxt == 1) ? 1 : 0;
  endtask

  initial begin
    int win;
    forever begin
      @(posedge clk);
      m_cyc++;
      if (rst) begin
        m_valid  = 1'b1;
        m_pipe1  = 3'b111;
        m_pipe2  = 3'b111;
        m_stable = 3'b111;
        m_press  = 3'b000;
        for (int i = 0; i < 3; i++) m_last_agree[i] = m_cyc;
        for (int a = 0; a < 2; a++) begin
          m_st[a] = 0; m_from_run[a] = 1'b0; m_age[a] = 0;
          e_en[a] = 0; e_ld[a] = 0; e_clr[a] = 0; e_val[a] = 0; e_led[a] = 0;
        end
      end else begin
        old_press = m_press;
        m_press   = 3'b000;
        for (int i = 0; i < 3; i++) begin
          if (m_pipe2[i] == m_stable[i]) begin
            m_last_agree[i] = m_cyc;
          end else if (m_cyc - m_last_agree[i] >= DB) begin
            m_press[i]      = m_stable[i];
            m_stable[i]     = ~m_stable[i];
            m_last_agree[i] = m_cyc;
          end
        end
        m_pipe2 = m_pipe1;
        m_pipe1 = key;
        win = old_press[0] ? 1 : old_press[1] ? 2 : old_press[2] ? 3 : 0;
        for (int a = 0; a < 2; a++) modelFsm(a, win);
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        for (int a = 0; a < 2; a++) begin
          checkOutput($sformatf("dut%0d STATE", a), {30'b0, st[a]}, 32'(m_st[a]));
          checkOutput($sformatf("dut%0d CNT_EN", a), {31'b0, en[a]}, 32'(e_en[a]));
          checkOutput($sformatf("dut%0d CNT_LOAD", a), {31'b0, ld[a]}, 32'(e_ld[a]));
          checkOutput($sformatf("dut%0d CNT_CLR", a), {31'b0, clr[a]}, 32'(e_clr[a]));
          checkOutput($sformatf("dut%0d LOAD_VAL", a), {28'b0, val[a]}, 32'(e_val[a]));
          checkOutput($sformatf("dut%0d RUN_LED", a), {31'b0, led[a]}, 32'(e_led[a]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    int n;
    int cnt;
    key  = 3'b111;
    rst  = 1'b1;
    sw   = 4'd0;
    cout = 1'b0;
    $display("[TB] reset");
    repeat (2) @(negedge clk);
    checkOutput("reset STATE", {30'b0, st[0]}, 32'd0);
    checkOutput("reset strobes", {29'b0, en[0], ld[0], clr[0]}, 32'd0);
    checkOutput("reset LOAD_VAL/RUN_LED", {27'b0, val[0], led[0]}, 32'd0);
    rst = 1'b0;
    applyStimulus(3'b111, 3);

    $display("[TB] start and count interval");
    key = 3'b011;
    waitSig(0, n);
    checkOutput("start press latency", n, 32'd6);
    checkOutput("RUN state", {30'b0, st[0]}, 32'd1);
    waitSig(1, n);
    checkOutput("first CNT_EN delay", n, 32'd4);
    @(negedge clk);
    waitSig(1, n);
    checkOutput("CNT_EN period", n + 1, 32'd4);
    applyStimulus(3'b111, 8);

    $display("[TB] pause");
    pressKey(3'b011);
    checkOutput("PAUSE state", {30'b0, st[0]}, 32'd2);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cnt += int'(en[0]);
      @(negedge clk);
    end
    checkOutput("pause no CNT_EN", cnt, 32'd0);

    $display("[TB] resume");
    key = 3'b011;
    waitSig(0, n);
    checkOutput("resume latency", n, 32'd6);
    waitSig(1, n);
    checkOutput("resume first CNT_EN", n, 32'd4);
    applyStimulus(3'b111, 8);
    pressKey(3'b011);

    $display("[TB] load from pause");
    sw  = 4'b0011;
    key = 3'b101;
    waitSig(2, n);
    checkOutput("load latency", n, 32'd6);
    checkOutput("LOAD state", {30'b0, st[0]}, 32'd3);
    checkOutput("LOAD_VAL 3", {28'b0, val[0]}, 32'd3);
    @(negedge clk);
    checkOutput("after load PAUSE", {30'b0, st[0]}, 32'd2);
    applyStimulus(3'b111, 8);
    sw  = 4'b1100;
    key = 3'b101;
    waitSig(2, n);
    checkOutput("load clamp latency", n, 32'd6);
    checkOutput("LOAD_VAL clamp", {28'b0, val[0]}, 32'd9);
    @(negedge clk);
    checkOutput("after clamp PAUSE", {30'b0, st[0]}, 32'd2);
    applyStimulus(3'b111, 8);

    $display("[TB] load from run");
    pressKey(3'b011);
    checkOutput("RUN before load", {30'b0, st[0]}, 32'd1);
    sw  = 4'd5;
    key = 3'b101;
    waitSig(2, n);
    checkOutput("run load latency", n, 32'd6);
    checkOutput("run LOAD_VAL", {28'b0, val[0]}, 32'd5);
    @(negedge clk);
    checkOutput("load returns RUN", {30'b0, st[0]}, 32'd1);
    applyStimulus(3'b111, 8);

    $display("[TB] clear priority");
    key = 3'b010;
    waitSig(3, n);
    checkOutput("clear latency", n, 32'd6);
    checkOutput("clear to IDLE", {30'b0, st[0]}, 32'd0);
    @(negedge clk);
    checkOutput("start dropped", {30'b0, st[0]}, 32'd0);
    applyStimulus(3'b111, 8);
    key = 3'b110;
    waitSig(3, n);
    checkOutput("idle clear latency", n, 32'd6);
    checkOutput("idle clear stays", {30'b0, st[0]}, 32'd0);
    applyStimulus(3'b111, 8);

    $display("[TB] debounce");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'b011, 2);
      applyStimulus(3'b111, 2);
    end
    applyStimulus(3'b111, 6);
    checkOutput("glitch rejected", {30'b0, st[0]}, 32'd0);
    applyStimulus(3'b011, 5);
    applyStimulus(3'b111, 10);
    checkOutput("long press single event", {30'b0, st[0]}, 32'd1);

    $display("[TB] reset in RUN and LOAD");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset in RUN STATE", {30'b0, st[0]}, 32'd0);
    checkOutput("reset in RUN strobes", {29'b0, en[0], ld[0], clr[0]}, 32'd0);
    applyStimulus(3'b111, 4);
    pressKey(3'b011);
    key = 3'b101;
    waitSig(2, n);
    checkOutput("load before reset", n, 32'd6);
    rst = 1'b1;
    key = 3'b111;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset in LOAD STATE", {30'b0, st[0]}, 32'd0);
    checkOutput("reset in LOAD strobes", {29'b0, en[0], ld[0], clr[0]}, 32'd0);
    applyStimulus(3'b111, 8);

    $display("[TB] auto-stop");
    key = 3'b011;
    waitSig(0, n);
    checkOutput("auto-stop start latency", n, 32'd6);
    cout = 1'b1;
    waitSig(1, n);
    checkOutput("terminal tick delay", n, 32'd4);
    checkOutput("wrap keeps RUN", {30'b0, st[0]}, 32'd1);
    checkOutput("auto-stop PAUSE", {30'b0, st[1]}, 32'd2);
    checkOutput("auto-stop no CNT_EN", {31'b0, en[1]}, 32'd0);
    cout = 1'b0;
    applyStimulus(3'b111, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
